// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM cash dispenser: FSM states,
// amount-select note counts and the default note value.
package atm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DISPENSE,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_e;

    localparam int NOTE_W           = 4;
    localparam int NOTE_VAL_DEFAULT = 100;

    localparam logic [NOTE_W-1:0] NOTES_SEL0 = 4'd1;
    localparam logic [NOTE_W-1:0] NOTES_SEL1 = 4'd2;
    localparam logic [NOTE_W-1:0] NOTES_SEL2 = 4'd5;
    localparam logic [NOTE_W-1:0] NOTES_SEL3 = 4'd10;

    function automatic logic [NOTE_W-1:0] notes_for(input logic [1:0] sel);
        case (sel)
            2'd0:    return NOTES_SEL0;
            2'd1:    return NOTES_SEL1;
            2'd2:    return NOTES_SEL2;
            default: return NOTES_SEL3;
        endcase
    endfunction

endpackage

// File: rtl/atm_cash_dispenser_if.sv
// Signal bundle between the withdraw stage / note mechanism (master side)
// and the cash dispenser (slave side).
interface atm_cash_dispenser_if #(
    parameter int BAL_W  = 16,
    parameter int CASS_W = 8
);
    logic              load_en;
    logic [BAL_W-1:0]  load_balance;
    logic              wd_pulse;
    logic [1:0]        amt_sel;
    logic              note_ack;
    logic              note_req;
    logic [BAL_W-1:0]  balance;
    logic [CASS_W-1:0] cassette_cnt;
    logic              busy;
    logic              done;
    logic              insufficient;
    logic              fault;

    modport master (
        output load_en, load_balance, wd_pulse, amt_sel, note_ack,
        input  note_req, balance, cassette_cnt, busy, done, insufficient, fault
    );

    modport slave (
        input  load_en, load_balance, wd_pulse, amt_sel, note_ack,
        output note_req, balance, cassette_cnt, busy, done, insufficient, fault
    );

endinterface

// File: rtl/atm_ack_timer.sv
// Note-acknowledge watchdog: cleared on start, counts while enabled and
// flags expiry once ACK_TIMEOUT cycles of waiting have been seen.
module atm_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    logic [TW-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/atm_cash_dispenser.sv
// Cash dispenser: validates a withdraw request against balance and cassette,
// then pays out one note per req/ack handshake with a timeout fault.
module atm_cash_dispenser
    import atm_pkg::*;
#(
    parameter int BAL_W         = 16,
    parameter int CASS_W        = 8,
    parameter int NOTE_VAL      = NOTE_VAL_DEFAULT,
    parameter int CASSETTE_INIT = 200,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    atm_cash_dispenser_if.slave  bus
);

    state_e            state, state_next;
    logic [BAL_W-1:0]  balance;
    logic [CASS_W-1:0] cassette_cnt;
    logic [NOTE_W-1:0] notes_rem;
    logic [BAL_W:0]    amount;
    logic              insuff_pulse;
    logic              bal_short;
    logic              notes_short;
    logic              timer_expired;

    atm_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   ((state == S_CHECK) || (state == S_GAP)),
        .en      (state == S_DISPENSE),
        .expired (timer_expired)
    );

    // One extra bit on the balance side keeps amounts above 2**BAL_W-1 comparable.
    assign bal_short   = ({1'b0, balance} < amount);
    assign notes_short = (32'(cassette_cnt) < 32'(notes_rem));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next   = state;
        insuff_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (!bus.load_en && bus.wd_pulse) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (bal_short || notes_short) begin
                    insuff_pulse = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    state_next = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                // An ack on the expiry cycle still counts as a dispensed note.
                if (bus.note_ack) begin
                    state_next = (notes_rem == NOTE_W'(1)) ? S_DONE : S_GAP;
                end else if (timer_expired) begin
                    state_next = S_FAULT;
                end
            end
            S_GAP:   state_next = S_DISPENSE;
            S_DONE:  state_next = S_IDLE;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            balance      <= '0;
            cassette_cnt <= CASS_W'(CASSETTE_INIT);
            notes_rem    <= '0;
            amount       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_en) begin
                        balance <= bus.load_balance;
                    end else if (bus.wd_pulse) begin
                        notes_rem <= notes_for(bus.amt_sel);
                        amount    <= (BAL_W+1)'(32'(notes_for(bus.amt_sel)) * NOTE_VAL);
                    end
                end
                S_DISPENSE: begin
                    if (bus.note_ack) begin
                        balance      <= balance - BAL_W'(NOTE_VAL);
                        cassette_cnt <= cassette_cnt - CASS_W'(1);
                        notes_rem    <= notes_rem - NOTE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.note_req     = (state == S_DISPENSE);
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE);
    assign bus.fault        = (state == S_FAULT);
    assign bus.insufficient = insuff_pulse;
    assign bus.balance      = balance;
    assign bus.cassette_cnt = cassette_cnt;

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Bench for atm_cash_dispenser: table-driven withdrawals checked through an
// outcome scoreboard, plus hand sequences for timeout, reset and ignore cases.
module tb_atm_cash_dispenser;

    typedef enum int {K_DONE, K_INSUF, K_FAULT} kind_e;

    typedef struct {
        kind_e kind;
        int    bal;
        int    cass;
        int    reqs;
    } exp_t;

    typedef struct {
        logic  do_load;
        int    load_val;
        int    sel;
        int    dly;
        kind_e kind;
        int    bal;
        int    cass;
        int    reqs;
    } vec_t;

    localparam int UNLIMITED = 1 << 30;

    logic clk;
    logic rst;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    int   ack_delay;
    int   ack_limit;
    int   acks_given;
    int   rises;

    atm_cash_dispenser_if #(.BAL_W(16), .CASS_W(8)) a ();
    atm_cash_dispenser_if #(.BAL_W(16), .CASS_W(8)) b ();

    atm_cash_dispenser u_dut (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    atm_cash_dispenser #(.CASSETTE_INIT(3)) u_dut_small (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (a.busy && k < budget) begin
            tick();
            k++;
        end
        check({tag, " back to idle"}, 32'(a.busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " balance"},      32'(a.balance), 0);
        check({tag, " cassette"},     32'(a.cassette_cnt), 200);
        check({tag, " note_req"},     32'(a.note_req), 0);
        check({tag, " busy"},         32'(a.busy), 0);
        check({tag, " done"},         32'(a.done), 0);
        check({tag, " insufficient"}, 32'(a.insufficient), 0);
        check({tag, " fault"},        32'(a.fault), 0);
    endtask

    // Note mechanism model: acks each request ack_delay cycles after it rises,
    // until ack_limit acks have been given in total.
    initial begin
        int req_age;
        req_age    = 0;
        acks_given = 0;
        a.note_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                a.note_ack = 1'b0;
                req_age    = 0;
            end else if (a.note_req && acks_given < ack_limit) begin
                if (req_age >= ack_delay) begin
                    a.note_ack = 1'b1;
                    acks_given++;
                    req_age = 0;
                end else begin
                    a.note_ack = 1'b0;
                    req_age++;
                end
            end else begin
                a.note_ack = 1'b0;
                req_age    = 0;
            end
        end
    end

    // Outcome monitor: pops one scoreboard entry per done/insufficient/fault event.
    initial begin
        logic prev_req;
        logic prev_fault;
        exp_t e;
        kind_e obs;
        prev_req   = 1'b0;
        prev_fault = 1'b0;
        rises      = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req   = 1'b0;
                prev_fault = 1'b0;
                rises      = 0;
            end else begin
                if (a.note_req && !prev_req) rises++;
                if (a.done || a.insufficient || (a.fault && !prev_fault)) begin
                    check("done/insufficient exclusive", 32'(a.done & a.insufficient), 0);
                    check("outcome was expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e   = sb.pop_front();
                        obs = a.done ? K_DONE : (a.insufficient ? K_INSUF : K_FAULT);
                        check("sb outcome kind", 32'(obs), 32'(e.kind));
                        check("sb note_req count", 32'(rises), 32'(e.reqs));
                        check("sb balance", 32'(a.balance), 32'(e.bal));
                        check("sb cassette", 32'(a.cassette_cnt), 32'(e.cass));
                    end
                    rises = 0;
                end
                prev_req   = a.note_req;
                prev_fault = a.fault;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   rises_seen;
        logic prev;
        int   k;

        n_tests   = 0;
        n_fail    = 0;
        ack_delay = 0;
        ack_limit = UNLIMITED;

        rst            = 1'b1;
        a.load_en      = 1'b0;
        a.load_balance = '0;
        a.wd_pulse     = 1'b0;
        a.amt_sel      = '0;
        b.load_en      = 1'b0;
        b.load_balance = '0;
        b.wd_pulse     = 1'b0;
        b.amt_sel      = '0;
        b.note_ack     = 1'b0;

        //            load  value sel dly kind     bal  cass reqs
        vecs[0] = '{1'b1,  300, 2, 0, K_INSUF,  300, 200, 0};
        vecs[1] = '{1'b1, 1000, 2, 2, K_DONE,   500, 195, 5};
        vecs[2] = '{1'b0,    0, 3, 0, K_INSUF,  500, 195, 0};
        vecs[3] = '{1'b0,    0, 0, 0, K_DONE,   400, 194, 1};
        vecs[4] = '{1'b0,    0, 1, 1, K_DONE,   200, 192, 2};
        vecs[5] = '{1'b1,  100, 0, 0, K_DONE,     0, 191, 1};
        vecs[6] = '{1'b0,    0, 0, 0, K_INSUF,    0, 191, 0};

        tick();
        tick();
        check_reset_outputs("reset");
        check("small dut reset cassette", 32'(b.cassette_cnt), 3);
        rst = 1'b0;

        // Cassette holds 3 notes, request is 5 with ample balance.
        b.load_en      = 1'b1;
        b.load_balance = 16'd5000;
        tick();
        b.load_en  = 1'b0;
        b.wd_pulse = 1'b1;
        b.amt_sel  = 2'd2;
        tick();
        b.wd_pulse = 1'b0;
        check("notes short insufficient", 32'(b.insufficient), 1);
        tick();
        check("notes short busy", 32'(b.busy), 0);
        check("notes short cassette", 32'(b.cassette_cnt), 3);
        check("notes short balance", 32'(b.balance), 5000);

        for (int i = 0; i < 7; i++) begin
            ack_delay = vecs[i].dly;
            ack_limit = UNLIMITED;
            if (vecs[i].do_load) begin
                a.load_en      = 1'b1;
                a.load_balance = 16'(vecs[i].load_val);
                tick();
                a.load_en = 1'b0;
            end
            a.wd_pulse = 1'b1;
            a.amt_sel  = 2'(vecs[i].sel);
            sb.push_back('{vecs[i].kind, vecs[i].bal, vecs[i].cass, vecs[i].reqs});
            tick();
            a.wd_pulse = 1'b0;
            check($sformatf("vec%0d insufficient timing", i), 32'(a.insufficient),
                  32'(vecs[i].kind == K_INSUF));
            wait_idle($sformatf("vec%0d", i), 300);
            check($sformatf("vec%0d balance", i), 32'(a.balance), 32'(vecs[i].bal));
            check($sformatf("vec%0d cassette", i), 32'(a.cassette_cnt), 32'(vecs[i].cass));
            check($sformatf("vec%0d scoreboard drained", i), 32'(sb.size()), 0);
        end

        // Load and withdraw pulses while busy must be ignored.
        ack_delay      = 5;
        a.load_en      = 1'b1;
        a.load_balance = 16'd500;
        tick();
        a.load_en  = 1'b0;
        a.wd_pulse = 1'b1;
        a.amt_sel  = 2'd0;
        sb.push_back('{K_DONE, 400, 190, 1});
        tick();
        a.load_en      = 1'b1;
        a.load_balance = 16'd9999;
        a.amt_sel      = 2'd3;
        repeat (3) tick();
        a.load_en  = 1'b0;
        a.wd_pulse = 1'b0;
        wait_idle("busy ignore", 100);
        check("busy ignore balance", 32'(a.balance), 400);
        check("busy ignore cassette", 32'(a.cassette_cnt), 190);
        check("busy ignore scoreboard drained", 32'(sb.size()), 0);

        // Ack the first note only; the second request must time out.
        ack_delay      = 0;
        ack_limit      = acks_given + 1;
        a.load_en      = 1'b1;
        a.load_balance = 16'd1000;
        tick();
        a.load_en  = 1'b0;
        a.wd_pulse = 1'b1;
        a.amt_sel  = 2'd1;
        sb.push_back('{K_FAULT, 900, 189, 2});
        tick();
        a.wd_pulse = 1'b0;
        rises_seen = 0;
        prev       = 1'b0;
        k          = 0;
        while (rises_seen < 2 && k < 100) begin
            tick();
            if (a.note_req && !prev) rises_seen++;
            prev = a.note_req;
            k++;
        end
        check("timeout second request seen", 32'(rises_seen), 2);
        repeat (15) tick();
        check("timeout fault not yet", 32'(a.fault), 0);
        check("timeout req still high", 32'(a.note_req), 1);
        tick();
        check("timeout fault raised", 32'(a.fault), 1);
        check("timeout req dropped", 32'(a.note_req), 0);
        check("timeout busy", 32'(a.busy), 1);
        check("timeout balance", 32'(a.balance), 900);
        check("timeout cassette", 32'(a.cassette_cnt), 189);

        a.load_en      = 1'b1;
        a.load_balance = 16'd55;
        a.wd_pulse     = 1'b1;
        a.amt_sel      = 2'd0;
        tick();
        a.load_en  = 1'b0;
        a.wd_pulse = 1'b0;
        repeat (5) tick();
        check("fault sticky", 32'(a.fault), 1);
        check("fault ignores load", 32'(a.balance), 900);
        check("fault scoreboard drained", 32'(sb.size()), 0);

        rst = 1'b1;
        tick();
        check_reset_outputs("reset from fault");
        rst       = 1'b0;
        ack_limit = UNLIMITED;

        // Reset asserted while a note is being requested.
        ack_delay      = 3;
        a.load_en      = 1'b1;
        a.load_balance = 16'd1000;
        tick();
        a.load_en  = 1'b0;
        a.wd_pulse = 1'b1;
        a.amt_sel  = 2'd3;
        tick();
        a.wd_pulse = 1'b0;
        k = 0;
        while (!a.note_req && k < 20) begin
            tick();
            k++;
        end
        check("mid reset in dispense", 32'(a.note_req), 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("reset mid dispense");
        rst = 1'b0;

        // Load wins over a simultaneous withdraw pulse.
        a.load_en      = 1'b1;
        a.load_balance = 16'd700;
        a.wd_pulse     = 1'b1;
        a.amt_sel      = 2'd0;
        tick();
        a.load_en  = 1'b0;
        a.wd_pulse = 1'b0;
        check("load+wd balance", 32'(a.balance), 700);
        check("load+wd busy", 32'(a.busy), 0);
        repeat (4) tick();
        check("load+wd no dispense", 32'(a.note_req | a.busy), 0);

        // Immediate ack gives the earliest done, three cycles after the pulse.
        ack_delay  = 0;
        a.wd_pulse = 1'b1;
        a.amt_sel  = 2'd0;
        sb.push_back('{K_DONE, 600, 199, 1});
        tick();
        a.wd_pulse = 1'b0;
        check("fast check busy", 32'(a.busy), 1);
        check("fast check no done", 32'(a.done), 0);
        tick();
        check("fast dispense req", 32'(a.note_req), 1);
        tick();
        check("fast done pulse", 32'(a.done), 1);
        wait_idle("fast", 10);
        check("fast balance", 32'(a.balance), 600);
        check("fast cassette", 32'(a.cassette_cnt), 199);
        check("fast scoreboard drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
